// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and its matching receiver.
`default_nettype none

package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Counter width for a modulus n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_tx_4bits_bit_timer.sv
// Bit-period timer: bit_end is high in the last clock cycle of each bit period.
`default_nettype none

module bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_end = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_tx_4bits.sv
// Parallel-in serial-out frame transmitter: start bit, WIDTH data bits LSB first, stop bit.
`default_nettype none

module serial_tx_4bits
  import serial_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic             ready,
  output logic             busy,
  output logic             tx,
  output logic             done
);

  localparam int IW = cnt_width(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;
  logic             timer_clear;

  // Timer is held at zero while idle so the start bit gets a full period from acceptance.
  assign timer_clear = (state_q == IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = START;
          shift_d = d;
          idx_d   = '0;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they change on the same edge as the state.
    case (state_d)
      START:   tx_d = START_BIT;
      DATA:    tx_d = shift_d[0];
      STOP:    tx_d = STOP_BIT;
      default: tx_d = IDLE_LEVEL;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = ~ready_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= IDLE_LEVEL;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_tx_4bits.sv
// Directed self-checking bench for serial_tx_4bits (C=4 instance plus a C=1 instance).
`default_nettype none

module tb_serial_tx_4bits;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [3:0] d = 4'h0;
  logic       ready, busy, tx, done;
  logic       load2 = 1'b0;
  logic [3:0] d2 = 4'h0;
  logic       ready2, busy2, tx2, done2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_tx_4bits #(.WIDTH(4), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .reset(reset), .load(load), .d(d),
    .ready(ready), .busy(busy), .tx(tx), .done(done)
  );

  serial_tx_4bits #(.WIDTH(4), .CLKS_PER_BIT(1)) dut_c1 (
    .clk(clk), .reset(reset), .load(load2), .d(d2),
    .ready(ready2), .busy(busy2), .tx(tx2), .done(done2)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level k cycles after acceptance for a C-cycle bit.
  function automatic logic exp_tx(input logic [3:0] v, input int k, input int c);
    int s;
    s = k / c;
    if (s == 0) return 1'b0;
    if (s <= 4) return v[s-1];
    return 1'b1;
  endfunction

  task automatic start_frame(input logic [3:0] val);
    load = 1'b1;
    d    = val;
    tick();
    load = 1'b0;
    d    = ~val;
  endtask

  // Entered just after the acceptance edge; leaves one cycle after the done cycle.
  task automatic check_frame(input logic [3:0] val, input bit inject,
                             input bit chain, input logic [3:0] nxt);
    for (int k = 0; k < 24; k++) begin
      check($sformatf("tx k=%0d", k), tx, exp_tx(val, k, 4));
      check("busy in frame", busy, 1'b1);
      check("ready in frame", ready, 1'b0);
      check("done in frame", done, 1'b0);
      if (inject && k == 8) begin
        load = 1'b1;
        d    = 4'b1111;
      end
      if (inject && k == 9) begin
        load = 1'b0;
        d    = 4'b0000;
      end
      tick();
    end
    check("done at end", done, 1'b1);
    check("ready at end", ready, 1'b1);
    check("busy at end", busy, 1'b0);
    check("tx at end", tx, 1'b1);
    if (chain) begin
      load = 1'b1;
      d    = nxt;
    end
    tick();
    if (chain) begin
      load = 1'b0;
      d    = ~nxt;
    end else begin
      check("done one cycle", done, 1'b0);
      check("tx idle after", tx, 1'b1);
      check("ready idle after", ready, 1'b1);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("tx in reset", tx, 1'b1);
    check("ready in reset", ready, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle tx", tx, 1'b1);
      check("idle ready", ready, 1'b1);
      check("idle busy", busy, 1'b0);
      check("idle done", done, 1'b0);
      check("idle tx c1", tx2, 1'b1);
      check("idle ready c1", ready2, 1'b1);
    end

    start_frame(4'b1011);
    check_frame(4'b1011, 1'b0, 1'b0, 4'h0);

    start_frame(4'b0001);
    check_frame(4'b0001, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      check("no 2nd frame tx", tx, 1'b1);
      check("no 2nd frame ready", ready, 1'b1);
      tick();
    end

    start_frame(4'b0101);
    check_frame(4'b0101, 1'b0, 1'b1, 4'b1010);
    check_frame(4'b1010, 1'b0, 1'b0, 4'h0);

    start_frame(4'b0110);
    repeat (10) tick();
    check("pre-abort busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("abort tx", tx, 1'b1);
    check("abort ready", ready, 1'b1);
    check("abort busy", busy, 1'b0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      check("no done after abort", done, 1'b0);
      check("idle after abort", tx, 1'b1);
      tick();
    end
    start_frame(4'b1001);
    check_frame(4'b1001, 1'b0, 1'b0, 4'h0);

    load2 = 1'b1;
    d2    = 4'b1000;
    tick();
    load2 = 1'b0;
    d2    = 4'b0111;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("c1 tx k=%0d", k), tx2, exp_tx(4'b1000, k, 1));
      check("c1 done low", done2, 1'b0);
      check("c1 busy", busy2, 1'b1);
      tick();
    end
    check("c1 done", done2, 1'b1);
    check("c1 ready", ready2, 1'b1);
    tick();
    check("c1 done pulse", done2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
